// File: rtl/pwm_compare_4bit.sv
// rtl/pwm_compare_4bit.sv - PWM comparator with double-buffered duty and period tick
// Optional period counter output enabled by PWM_PERIOD_COUNT_EN.
module pwm_compare_4bit #(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             period_tick,
   output logic             running
`ifdef PWM_PERIOD_COUNT_EN
   ,
   output logic [7:0]       period_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_prev_count;
   logic [WIDTH-1:0] r_active_duty;
   logic [WIDTH-1:0] r_pending_duty;
   logic             r_pending_flag;
   logic             r_pwm;
   logic             r_tick;

   logic             w_wrap;
   logic             w_resync;
   logic             w_load;
   logic             w_accept;
   logic [WIDTH-1:0] w_duty_eff;

   assign w_wrap   = (r_prev_count == '1) && (count == '0);
   assign w_resync = (count != (r_prev_count + WIDTH'(1))) && !w_wrap;

   // Pending duty is promoted only on a wrap while synchronised or running.
   assign w_load     = (r_state != IDLE) && w_wrap && r_pending_flag;
   assign w_accept   = duty_valid && !r_pending_flag;
   assign w_duty_eff = w_load ? r_pending_duty : r_active_duty;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (enable) w_next_state = SYNC;
         end
         SYNC: begin
            if (!enable)     w_next_state = IDLE;
            else if (w_wrap) w_next_state = RUN;
         end
         RUN: begin
            if (!enable)       w_next_state = IDLE;
            else if (w_resync) w_next_state = SYNC;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_prev_count   <= '0;
         r_active_duty  <= RESET_DUTY;
         r_pending_duty <= RESET_DUTY;
         r_pending_flag <= 1'b0;
         r_pwm          <= 1'b0;
         r_tick         <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_prev_count <= count;
         r_tick       <= w_wrap;
         // Gate on the next state so the first compare after a wrap lands with running.
         r_pwm        <= (w_next_state == RUN) && (count < w_duty_eff);
         if (w_load) begin
            r_active_duty  <= r_pending_duty;
            r_pending_flag <= 1'b0;
         end else if (w_accept) begin
            r_pending_duty <= duty_in;
            r_pending_flag <= 1'b1;
         end
      end
   end

   assign duty_ready  = !r_pending_flag;
   assign pwm_out     = r_pwm;
   assign period_tick = r_tick;
   assign running     = (r_state == RUN);

`ifdef PWM_PERIOD_COUNT_EN
   logic [7:0] r_period_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_period_count <= 8'd0;
      end else if ((r_state != IDLE) && (w_next_state == IDLE)) begin
         r_period_count <= 8'd0;
      end else if (r_tick && (r_state == RUN)) begin
         r_period_count <= r_period_count + 8'd1;
      end
   end

   assign period_count = r_period_count;
`endif

endmodule

// File: doc/pwm_compare_4bit.md
Name: pwm_compare_4bit

Overview:
- Downstream consumer of the free-running 4-bit up counter output.
- Compares the incoming count against a double-buffered duty value to produce a registered PWM output, plus a one-cycle period tick at each counter wrap.
- New duty values arrive over a valid/ready handshake. They are applied only on a period boundary, so no glitched or partial periods occur.

Parameters:
- WIDTH, 4, width of count and duty; one period = 2**WIDTH clocks.
- RESET_DUTY, 0, value of the active and pending duty registers after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- count  input  WIDTH  count value from the upstream up counter; advances by 1 per clock.
- enable  input  1  run request; low forces IDLE.
- duty_in  input  WIDTH  requested duty in counts high per period.
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  block can accept a duty value (no update pending).
- pwm_out  output  1  registered PWM output.
- period_tick  output  1  one-cycle pulse on the cycle after a wrap is detected.
- running  output  1  high while the FSM is in RUN.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset:
  - state = IDLE; prev_count = 0; active_duty = pending_duty = RESET_DUTY; pending_flag = 0.
  - pwm_out = 0, period_tick = 0, running = 0, duty_ready = 1.
- Wrap detect (combinational): wrap = (prev_count == 2**WIDTH-1) && (count == 0). prev_count registers count every cycle in all states.
- Resync detect: resync = (count != prev_count+1 mod 2**WIDTH) && !wrap. This covers an upstream counter reset mid-period or a stall.
- FSM transitions:
  - IDLE: pwm_out=0. enable=1 -> SYNC.
  - SYNC: pwm_out=0. Waits for the first wrap. enable=0 -> IDLE. wrap -> RUN, and active_duty loads pending_duty if pending_flag.
  - RUN: enable=0 -> IDLE. resync -> SYNC. Otherwise stays in RUN.
  - enable=0 has priority over wrap and resync.
- PWM output in RUN: pwm_out <= (count < active_duty), registered, so latency is 1 clock from count.
  - duty 0 -> always low.
  - duty 15 -> high 15 of 16 cycles. A 100% duty is not reachable.
  - In the cycle a wrap occurs, the compare uses the newly loaded active_duty.
- period_tick <= wrap in every state, including IDLE. It is a pulse exactly 1 cycle wide.
- Handshake:
  - duty_ready = !pending_flag.
  - Transfer occurs when duty_valid && duty_ready: pending_duty <= duty_in and pending_flag <= 1.
  - At a wrap in SYNC or RUN with pending_flag=1: active_duty <= pending_duty, pending_flag <= 0, and duty_ready rises on the next cycle.
  - A transfer in the same cycle as a wrap (pending_flag was 0) is applied at the following wrap, not this one.
  - duty_in is ignored while duty_ready=0. The producer must hold duty_valid until the transfer completes.
  - In IDLE, pending updates are held and not applied.
- Reset mid-operation forces all registers to their reset values immediately. The pending update is lost.

Optional Feature:
- Macro: PWM_PERIOD_COUNT_EN.
- Defined:
  - Adds output port period_count [7:0].
  - period_count increments by 1 on every period_tick while running=1, wraps 255 -> 0, and clears to 0 on reset and on entry to IDLE.
- Undefined:
  - Port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-run (reset pulsed while count=9, RUN, duty 8, pending_flag=1) -> pwm_out, running, period_tick = 0 immediately; duty_ready=1; active_duty = RESET_DUTY; the pending update is discarded.
- Steady PWM: enable=1, load duty 5 in IDLE, counter free-running from 0.
  - running rises one clock after the first 15->0 wrap.
  - pwm_out is then high for counts 0-4 and low for counts 5-15, delayed 1 clock.
  - period_tick pulses once per 16 clocks.
- Duty boundary values:
  - duty 0 -> pwm_out never high over 3 periods.
  - duty 15 -> 15 high and 1 low per period.
- Handshake and shadowing: in RUN with duty 4, send duty 12 at count=7.
  - duty_ready drops the next cycle.
  - A second value 2 held valid meanwhile is not accepted.
  - Duty 12 takes effect only from the next count=0.
  - duty_ready returns 1 the cycle after the wrap, then duty 2 is accepted.
- Simultaneous wrap and transfer: present duty 9 exactly on the cycle count 15->0 with no pending update -> current period still uses the old duty; 9 is applied at the following wrap.
- Upstream disturbance and enable:
  - Force count from 6 to 0 while in RUN -> SYNC, pwm_out=0 until the next 15->0 wrap.
  - Deassert enable during a wrap cycle -> IDLE wins.
  - With PWM_PERIOD_COUNT_EN defined, period_count clears to 0 on IDLE entry.
